// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 serial receiver with runtime baud divisor, start-bit glitch
//            rejection, one-cycle done / frame_err strobes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [15:0]           CLKS_PER_BIT,
  input  logic                  data_bit,
  output logic [data_width-1:0] data_bus,
  output logic                  done,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int IDX_W = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_width - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, rx_s_q, rx_d_q;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           n_reg_q, n_reg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [data_width-1:0] shreg_q, shreg_d;
  logic [data_width-1:0] data_bus_q, data_bus_d;
  logic                  stop_ok_q, stop_ok_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;

  logic [15:0] w_half_m1;
  logic [15:0] w_n_m1;
  logic        w_fall;

  assign w_half_m1 = (n_reg_q >> 1) - 16'd1;
  assign w_n_m1    = n_reg_q - 16'd1;
  // Only a 1->0 transition arms reception; a held-low line never retriggers.
  assign w_fall    = rx_d_q & ~rx_s_q;

  // Two-flop synchronizer plus one delay flop for edge detection; idle is 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= data_bit;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      n_reg_q    <= 16'd0;
      idx_q      <= '0;
      shreg_q    <= '0;
      data_bus_q <= '0;
      stop_ok_q  <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_reg_q    <= n_reg_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      data_bus_q <= data_bus_d;
      stop_ok_q  <= stop_ok_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic: mid-bit sampling driven by a per-frame latched divisor.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_reg_d    = n_reg_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    data_bus_d = data_bus_q;
    stop_ok_d  = stop_ok_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_fall) begin
          state_d = START_BIT;
          cnt_d   = 16'd0;
          idx_d   = '0;
          n_reg_d = CLKS_PER_BIT;
        end
      end
      START_BIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == w_half_m1) begin
          cnt_d   = 16'd0;
          // Line back high at mid start bit means it was only a glitch.
          state_d = rx_s_q ? IDLE : DATA_BITS;
        end
      end
      DATA_BITS: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == w_n_m1) begin
          cnt_d          = 16'd0;
          shreg_d[idx_q] = rx_s_q;
          if (idx_q == LAST_IDX) begin
            state_d = STOP_BIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP_BIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == w_n_m1) begin
          cnt_d     = 16'd0;
          stop_ok_d = rx_s_q;
          if (rx_s_q) begin
            data_bus_d = shreg_q;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle launches the strobe; second returns to IDLE so the
        // strobe is exactly one cycle wide.
        if (!(done_q | ferr_q)) begin
          done_d = stop_ok_q;
          ferr_d = ~stop_ok_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_bus  = data_bus_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
